// File: rtl/frame_update_sequencer.sv
// Frame update sequencer: turns the frame-rate divider tick into a game-logic
// update handshake followed by a draw handshake. One late frame is queued;
// further late frames are dropped, counted and flagged. Optional handshake
// timeout aborts a stuck frame.
module frame_update_sequencer #(
  parameter int FRAME_CNT_W = 16,
  parameter int TIMEOUT     = 1_000_000,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_en,
  output logic                   update_req,
  input  logic                   update_done,
  output logic                   draw_req,
  input  logic                   draw_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [DROP_CNT_W-1:0]  drop_count,
  output logic                   overrun,
  output logic                   timeout_err,
  input  logic                   clear_flags
);

  // Timer only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DRAW   = 2'd2
  } state_t;

  state_t           state;
  logic             pending;
  logic [TMR_W-1:0] timer;

  logic in_hs;     // in either handshake state
  logic upd_ack;   // update_done accepted this cycle
  logic drw_ack;   // draw_done accepted this cycle
  logic tmr_exp;   // handshake has run out of time with no done
  logic late;      // frame tick arriving while a frame is in flight
  logic drop;      // late tick with the queue slot already taken

  // Event decode: done inputs only count in their own state; a tick that
  // coincides with an accepted draw_done starts the next frame instead of
  // being treated as late.
  always_comb begin
    in_hs   = (state != IDLE);
    upd_ack = (state == UPDATE) && update_done;
    drw_ack = (state == DRAW) && draw_done;
    tmr_exp = (TIMEOUT != 0) && in_hs && (timer == TMR_LAST) && !upd_ack && !drw_ack;
    late    = frame_en && in_hs && !drw_ack;
    drop    = late && pending;
  end

  // Sequencer FSM with registered request/busy outputs, queue slot, timer,
  // frame counter and sticky error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      timer       <= '0;
      update_req  <= 1'b0;
      draw_req    <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value and later assignments in this block simply
      // override the defaults made above them.
      timer <= in_hs ? timer + 1'b1 : '0;

      if (late && !pending) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_en || pending) begin
            state      <= UPDATE;
            update_req <= 1'b1;
            busy       <= 1'b1;
            pending    <= 1'b0;
            timer      <= '0;
          end
        end

        UPDATE: begin
          if (upd_ack) begin
            state      <= DRAW;
            update_req <= 1'b0;
            draw_req   <= 1'b1;
            timer      <= '0;
          end else if (tmr_exp) begin
            state      <= IDLE;
            update_req <= 1'b0;
            busy       <= 1'b0;
            pending    <= 1'b0;
            timer      <= '0;
          end
        end

        DRAW: begin
          if (drw_ack) begin
            frame_count <= frame_count + 1'b1;
            draw_req    <= 1'b0;
            timer       <= '0;
            if (pending || frame_en) begin
              // Queued frame starts now; a coincident tick refills the slot.
              state      <= UPDATE;
              update_req <= 1'b1;
              pending    <= pending && frame_en;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tmr_exp) begin
            state    <= IDLE;
            draw_req <= 1'b0;
            busy     <= 1'b0;
            pending  <= 1'b0;
            timer    <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          update_req <= 1'b0;
          draw_req   <= 1'b0;
          busy       <= 1'b0;
          pending    <= 1'b0;
          timer      <= '0;
        end
      endcase

      // Sticky flags: a set event in the same cycle as clear_flags wins.
      overrun     <= (overrun && !clear_flags) || drop;
      timeout_err <= (timeout_err && !clear_flags) || tmr_exp;

      if (drop) begin
        if (clear_flags) begin
          drop_count <= DROP_CNT_W'(1);
        end else if (!(&drop_count)) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (clear_flags) begin
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Self-checking bench for frame_update_sequencer: table-driven directed
// sequences, hand-written corner cases, and randomized traffic checked
// against a frame-queue reference model.
module tb_frame_update_sequencer;

  localparam int FW  = 16;
  localparam int TMO = 8;
  localparam int DW  = 8;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_en = 1'b0;
  logic          update_done = 1'b0;
  logic          draw_done = 1'b0;
  logic          clear_flags = 1'b0;
  logic          update_req, draw_req, busy, overrun, timeout_err;
  logic [FW-1:0] frame_count;
  logic [DW-1:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  frame_update_sequencer #(
    .FRAME_CNT_W(FW),
    .TIMEOUT    (TMO),
    .DROP_CNT_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_en   (frame_en),
    .update_req (update_req),
    .update_done(update_done),
    .draw_req   (draw_req),
    .draw_done  (draw_done),
    .busy       (busy),
    .frame_count(frame_count),
    .drop_count (drop_count),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Reference model: frames in flight (0..2: one active + one queued), the
  // stage of the active frame (0 = game update, 1 = draw) and its age.
  // ---------------------------------------------------------------------
  int m_out, m_stage, m_age, m_frames, m_drops;
  bit m_ovr, m_tmo;

  task automatic model_reset();
    m_out = 0; m_stage = 0; m_age = 0; m_frames = 0; m_drops = 0;
    m_ovr = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic model_step(input bit fe, input bit ud, input bit dd, input bit cf);
    bit drop_now, tmo_now;
    drop_now = 1'b0;
    tmo_now  = 1'b0;
    if (m_out == 0) begin
      if (fe) begin
        m_out = 1; m_stage = 0; m_age = 0;
      end
    end else begin
      if (fe && !(m_stage == 1 && dd)) begin
        if (m_out == 1) m_out = 2;
        else drop_now = 1'b1;
      end
      if (m_stage == 0 && ud) begin
        m_stage = 1; m_age = 0;
      end else if (m_stage == 1 && dd) begin
        m_frames++;
        m_out = m_out - 1 + (fe ? 1 : 0);
        m_stage = 0; m_age = 0;
      end else if (m_age == TMO - 1) begin
        tmo_now = 1'b1; m_out = 0; m_age = 0;
      end else begin
        m_age++;
      end
    end
    if (cf) begin
      m_ovr = 1'b0; m_tmo = 1'b0; m_drops = 0;
    end
    if (drop_now) begin
      m_ovr = 1'b1;
      if (m_drops < DROP_MAX) m_drops++;
    end
    if (tmo_now) m_tmo = 1'b1;
  endtask

  // Output bundle: {3'b0, update_req, draw_req, busy, overrun, timeout_err,
  // frame_count[15:0], drop_count[7:0]}
  function automatic logic [31:0] mk(bit ureq, bit dreq, bit bsy, bit ovr, bit tmo,
                                     int fc, int dc);
    return {3'b0, ureq, dreq, bsy, ovr, tmo, 16'(fc), 8'(dc)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {3'b0, update_req, draw_req, busy, overrun, timeout_err, frame_count, drop_count};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return mk(m_out > 0 && m_stage == 0, m_out > 0 && m_stage == 1, m_out > 0,
              m_ovr, m_tmo, m_frames, m_drops);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, model follows the posedge, compare at next negedge.
  task automatic step(input bit fe, input bit ud, input bit dd, input bit cf);
    frame_en    = fe;
    update_done = ud;
    draw_done   = dd;
    clear_flags = cf;
    @(posedge clk);
    model_step(fe, ud, dd, cf);
    @(negedge clk);
    check("model", dut_vec(), mdl_vec());
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_en = 1'b0; update_done = 1'b0; draw_done = 1'b0; clear_flags = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int          n;
    bit          fe, ud, dd, cf;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit fe, input bit ud, input bit dd, input bit cf,
                     input logic [31:0] e);
    vec_t v;
    v.n = n; v.fe = fe; v.ud = ud; v.dd = dd; v.cf = cf; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    model_reset();

    // -------------------- directed table --------------------
    // Basic frame: tick@10, update_done@14, draw_done@20.
    add(10, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0));
    add(3,  0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 0));
    add(5,  0, 0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0));
    add(1,  0, 0, 1, 0, mk(0, 0, 0, 0, 0, 1, 0));
    // One late frame queued and served straight after the draw.
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0));
    add(1,  0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0));
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0));
    add(1,  0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 1, 0));
    add(5,  0, 0, 0, 0, mk(0, 1, 1, 0, 0, 1, 0));
    add(1,  0, 0, 1, 0, mk(1, 0, 1, 0, 0, 2, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 2, 0));
    add(1,  0, 0, 1, 0, mk(0, 0, 0, 0, 0, 3, 0));
    // Two late frames: second one dropped, only one queued.
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 3, 0));
    add(1,  0, 0, 0, 0, mk(1, 0, 1, 0, 0, 3, 0));
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 3, 0));
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 1, 0, 3, 1));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 1, 0, 3, 1));
    add(1,  0, 0, 1, 0, mk(1, 0, 1, 1, 0, 4, 1));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 1, 0, 4, 1));
    add(1,  0, 0, 1, 0, mk(0, 0, 0, 1, 0, 5, 1));
    add(1,  0, 0, 0, 1, mk(0, 0, 0, 0, 0, 5, 0));
    // Tick coinciding with draw_done, nothing queued.
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 5, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 5, 0));
    add(1,  1, 0, 1, 0, mk(1, 0, 1, 0, 0, 6, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 6, 0));
    add(1,  0, 0, 1, 0, mk(0, 0, 0, 0, 0, 7, 0));
    // Tick coinciding with draw_done while one frame is queued: no drop.
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 7, 0));
    add(1,  1, 0, 0, 0, mk(1, 0, 1, 0, 0, 7, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 7, 0));
    add(1,  1, 0, 1, 0, mk(1, 0, 1, 0, 0, 8, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 8, 0));
    add(1,  0, 0, 1, 0, mk(1, 0, 1, 0, 0, 9, 0));
    add(1,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 9, 0));
    add(1,  0, 0, 1, 0, mk(0, 0, 0, 0, 0, 10, 0));

    // Reset state, held inputs idle.
    #1;
    check("reset_state", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        step(tbl[i].fe, tbl[i].ud, tbl[i].dd, tbl[i].cf);
        check($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
      end
    end

    // -------------------- timeout --------------------
    do_reset();
    step(1, 0, 0, 0);
    check("tmo_start", dut_vec(), mk(1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < TMO - 1; i++) begin
      step(0, 0, 0, 0);
      check("tmo_hold", dut_vec(), mk(1, 0, 1, 0, 0, 0, 0));
    end
    step(0, 0, 0, 0);
    check("tmo_abort", dut_vec(), mk(0, 0, 0, 0, 1, 0, 0));
    step(0, 0, 0, 1);
    check("tmo_clear", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    // A done on the very last allowed cycle is still accepted.
    step(1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("tmo_last_cycle_done", dut_vec(), mk(0, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, 0);
    check("tmo_last_cycle_draw", dut_vec(), mk(0, 0, 0, 0, 0, 1, 0));

    // -------------------- drop saturation and clear --------------------
    do_reset();
    for (int i = 0; i < 620; i++) step(1, 1, 1, 0);
    check("drop_saturate", {23'b0, overrun, drop_count}, {23'b0, 1'b1, 8'(DROP_MAX)});
    step(0, 0, 0, 1);
    check("drop_clear", {22'b0, overrun, timeout_err, drop_count}, 32'd0);
    step(1, 0, 0, 1);
    check("drop_clear_collide", {23'b0, overrun, drop_count}, {23'b0, 1'b1, 8'd1});

    // -------------------- reset mid-draw --------------------
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("pre_rst_draw", dut_vec(), mk(0, 1, 1, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0, 1, 0);
    check("rst_done_ignored", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 0);
    check("rst_restart", dut_vec(), mk(1, 0, 1, 0, 0, 0, 0));

    // -------------------- randomized against the model --------------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) == 0, $urandom_range(2) == 0,
           $urandom_range(2) == 0, $urandom_range(31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
